// File: rtl/servo_move_sequencer.sv
// servo_move_sequencer
//   Wishbone slave that queues servo move commands in a FIFO and executes them
//   one at a time: each move ramps one pulse-width channel toward its target at
//   a programmable rate per tick, then holds for a number of ticks.
//
// Ports
//   clk, rst      clock; asynchronous active-low reset
//   wb_*          Wishbone slave (registered ack, one wait state; [5:2] decoded)
//   pw_o          8 x 16-bit pulse widths in us, channel n = pw_o[16n+15:16n]
//   busy_o        FSM not idle or FIFO not empty
//   irq_o         CTRL.irq_en & STATUS.done
//
// Build option
//   SERVO_LIMIT_EN  clamp targets into [PW_MIN, PW_MAX] at load, STATUS[5] sticky
module servo_move_sequencer #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned STEP_DIV   = 100000,
  parameter int unsigned PW_RESET   = 1500,
  parameter int unsigned PW_MIN     = 500,
  parameter int unsigned PW_MAX     = 2500
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  wb_adr_i,
  input  logic [31:0]  wb_dat_i,
  output logic [31:0]  wb_dat_o,
  input  logic [3:0]   wb_sel_i,
  input  logic         wb_we_i,
  input  logic         wb_stb_i,
  input  logic         wb_cyc_i,
  output logic         wb_ack_o,
  output logic [127:0] pw_o,
  output logic         busy_o,
  output logic         irq_o
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned TW  = $clog2(STEP_DIV);
  localparam int unsigned NCH = 8;

  localparam logic [3:0] A_CMD    = 4'h0;
  localparam logic [3:0] A_STATUS = 4'h1;
  localparam logic [3:0] A_CTRL   = 4'h2;
  localparam logic [3:0] A_RATE   = 4'h3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RAMP = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic                 ack_q, ack_d;
  logic [31:0]          dat_q, dat_d;
  logic [31:0]          fifo_q [FIFO_DEPTH];
  logic [31:0]          fifo_d [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 enable_q, enable_d;
  logic                 irq_en_q, irq_en_d;
  logic [15:0]          rate_q, rate_d;
  logic                 ovf_q, ovf_d;
  logic                 done_q, done_d;
  logic [NCH-1:0][15:0] pw_q, pw_d;
  logic [2:0]           cur_servo_q, cur_servo_d;
  logic [15:0]          cur_target_q, cur_target_d;
  logic [12:0]          hold_cnt_q, hold_cnt_d;
  logic [TW-1:0]        presc_q, presc_d;
  logic                 busy_q, busy_d;
  logic                 irq_q, irq_d;
`ifdef SERVO_LIMIT_EN
  logic                 clamped_q, clamped_d;
  logic                 clamp_hit;
`endif

  logic [3:0]  reg_idx;
  logic        acc, wr_acc, rd_acc;
  logic        tick, full, empty;
  logic        flush, push_req, push_ok, pop, done_set;
  logic [31:0] head;
  logic [15:0] load_target;
  logic [15:0] cur_pw, diff, step, next_pw;
  logic        ramp_up;
  logic [31:0] status, rdata;
  logic        unused_ok;

  // Bus decode: an access is taken on the cycle that raises ack
  assign reg_idx  = wb_adr_i[5:2];
  assign acc      = wb_stb_i & wb_cyc_i & ~ack_q;
  assign wr_acc   = acc & wb_we_i;
  assign rd_acc   = acc & ~wb_we_i;

  assign tick     = (presc_q == TW'(STEP_DIV - 1));
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);

  // Flush wins over any push; a full FIFO still accepts a push while popping
  assign flush    = wr_acc & (reg_idx == A_CTRL) & wb_dat_i[1];
  assign push_req = wr_acc & (reg_idx == A_CMD) & ~flush;
  assign pop      = (state_q == S_LOAD) & ~flush;
  assign push_ok  = push_req & (~full | pop);
  assign done_set = (state_q == S_HOLD) & enable_q & (hold_cnt_q == '0) & empty & ~flush;

  assign unused_ok = ^{wb_sel_i, wb_adr_i[31:6], wb_adr_i[1:0]
`ifndef SERVO_LIMIT_EN
                       , 16'(PW_MIN), 16'(PW_MAX)
`endif
                      };

  // Head-of-queue target, optionally clamped into the legal servo range
  always_comb begin
    head        = fifo_q[rd_ptr_q];
    load_target = head[15:0];
`ifdef SERVO_LIMIT_EN
    clamp_hit   = 1'b0;
    if (head[15:0] < 16'(PW_MIN)) begin
      load_target = 16'(PW_MIN);
      clamp_hit   = 1'b1;
    end else if (head[15:0] > 16'(PW_MAX)) begin
      load_target = 16'(PW_MAX);
      clamp_hit   = 1'b1;
    end
`endif
  end

  // Saturated ramp step for the active channel; RATE=0 jumps to target
  always_comb begin
    cur_pw  = pw_q[cur_servo_q];
    ramp_up = (cur_target_q > cur_pw);
    diff    = ramp_up ? (cur_target_q - cur_pw) : (cur_pw - cur_target_q);
    step    = ((rate_q == 16'd0) || (rate_q >= diff)) ? diff : rate_q;
    next_pw = ramp_up ? (cur_pw + step) : (cur_pw - step);
  end

  // Status word and read mux
  always_comb begin
    status        = '0;
    status[0]     = (state_q != S_IDLE) | ~empty;
    status[1]     = full;
    status[2]     = empty;
    status[3]     = ovf_q;
    status[4]     = done_q;
`ifdef SERVO_LIMIT_EN
    status[5]     = clamped_q;
`endif
    status[11:8]  = 4'(count_q);

    rdata = '0;
    case (reg_idx)
      A_STATUS: rdata = status;
      A_CTRL:   rdata = {29'd0, irq_en_q, 1'b0, enable_q};
      A_RATE:   rdata = {16'd0, rate_q};
      default:  if (reg_idx[3]) rdata = {16'd0, pw_q[reg_idx[2:0]]};
    endcase
  end

  // Next-state: bus registers, FIFO, sequencer FSM, registered outputs
  always_comb begin
    state_d      = state_q;
    ack_d        = acc;
    dat_d        = rd_acc ? rdata : 32'd0;
    fifo_d       = fifo_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    enable_d     = enable_q;
    irq_en_d     = irq_en_q;
    rate_d       = rate_q;
    ovf_d        = ovf_q;
    done_d       = done_q;
    pw_d         = pw_q;
    cur_servo_d  = cur_servo_q;
    cur_target_d = cur_target_q;
    hold_cnt_d   = hold_cnt_q;
    presc_d      = tick ? '0 : presc_q + TW'(1);
`ifdef SERVO_LIMIT_EN
    clamped_d    = clamped_q;
`endif

    // Register writes
    if (wr_acc) begin
      case (reg_idx)
        A_STATUS: begin
          if (wb_dat_i[3]) ovf_d  = 1'b0;
          if (wb_dat_i[4]) done_d = 1'b0;
`ifdef SERVO_LIMIT_EN
          if (wb_dat_i[5]) clamped_d = 1'b0;
`endif
        end
        A_CTRL: begin
          enable_d = wb_dat_i[0];
          irq_en_d = wb_dat_i[2];
        end
        A_RATE:  rate_d = wb_dat_i[15:0];
        default: ;
      endcase
    end

    // Command FIFO
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_req & ~push_ok) ovf_d = 1'b1;
      if (push_ok) begin
        fifo_d[wr_ptr_q] = wb_dat_i;
        wr_ptr_d         = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop);
    end

    // Sequencer; RAMP and HOLD are frozen while disabled
    case (state_q)
      S_IDLE: if (enable_q && !empty) state_d = S_LOAD;
      S_LOAD: begin
        cur_servo_d  = head[31:29];
        hold_cnt_d   = head[28:16];
        cur_target_d = load_target;
`ifdef SERVO_LIMIT_EN
        if (clamp_hit) clamped_d = 1'b1;
`endif
        state_d      = S_RAMP;
      end
      S_RAMP: if (enable_q) begin
        if (cur_pw == cur_target_q) state_d = S_HOLD;
        else if (tick)              pw_d[cur_servo_q] = next_pw;
      end
      S_HOLD: if (enable_q) begin
        if (hold_cnt_q == '0) state_d = empty ? S_IDLE : S_LOAD;
        else if (tick)        hold_cnt_d = hold_cnt_q - 13'd1;
      end
      default: state_d = S_IDLE;
    endcase

    if (done_set) done_d = 1'b1;
    if (flush) begin
      state_d = S_IDLE;
      pw_d    = pw_q;
    end

    busy_d = (state_d != S_IDLE) | (count_d != '0);
    irq_d  = irq_en_d & done_d;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      ack_q        <= 1'b0;
      dat_q        <= '0;
      fifo_q       <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      enable_q     <= 1'b0;
      irq_en_q     <= 1'b0;
      rate_q       <= '0;
      ovf_q        <= 1'b0;
      done_q       <= 1'b0;
      pw_q         <= {NCH{16'(PW_RESET)}};
      cur_servo_q  <= '0;
      cur_target_q <= '0;
      hold_cnt_q   <= '0;
      presc_q      <= '0;
      busy_q       <= 1'b0;
      irq_q        <= 1'b0;
`ifdef SERVO_LIMIT_EN
      clamped_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ack_q        <= ack_d;
      dat_q        <= dat_d;
      fifo_q       <= fifo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      enable_q     <= enable_d;
      irq_en_q     <= irq_en_d;
      rate_q       <= rate_d;
      ovf_q        <= ovf_d;
      done_q       <= done_d;
      pw_q         <= pw_d;
      cur_servo_q  <= cur_servo_d;
      cur_target_q <= cur_target_d;
      hold_cnt_q   <= hold_cnt_d;
      presc_q      <= presc_d;
      busy_q       <= busy_d;
      irq_q        <= irq_d;
`ifdef SERVO_LIMIT_EN
      clamped_q    <= clamped_d;
`endif
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign pw_o     = pw_q;
  assign busy_o   = busy_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_servo_move_sequencer.sv
// Self-checking bench for servo_move_sequencer (STEP_DIV = 4).
// Reference model: per-channel pulse widths plus a queue of pending moves;
// every observed pw change must be the next saturated step of the head move.
`timescale 1ns/1ps
module tb_servo_move_sequencer;

  localparam int unsigned STEP_DIV = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]   wb_sel_i;
  logic         wb_we_i, wb_stb_i, wb_cyc_i, wb_ack_o;
  logic [127:0] pw_o;
  logic         busy_o, irq_o;

  servo_move_sequencer #(.STEP_DIV(STEP_DIV)) dut (
    .clk(clk), .rst(rst),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i),
    .wb_cyc_i(wb_cyc_i), .wb_ack_o(wb_ack_o),
    .pw_o(pw_o), .busy_o(busy_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0;
  int idle_cyc = 0;
  int chg_cyc[$];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct { int s; int t; int h; } cmd_t;
  cmd_t mq[$];
  int   mpw[8];
  int   mrate;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int clampt(input int t);
`ifdef SERVO_LIMIT_EN
    if (t < 500)  return 500;
    if (t > 2500) return 2500;
`endif
    return t;
  endfunction

  function automatic int step_to(input int cur, input int tgt, input int rate);
    int d;
    int ad;
    d  = tgt - cur;
    ad = (d < 0) ? -d : d;
    if (rate == 0 || rate >= ad) return tgt;
    return (d > 0) ? cur + rate : cur - rate;
  endfunction

  function automatic logic [127:0] model_vec();
    logic [127:0] v;
    v = '0;
    for (int c = 0; c < 8; c++) v[16*c +: 16] = 16'(mpw[c]);
    return v;
  endfunction

  task automatic retire();
    while (mq.size() > 0 && mpw[mq[0].s] == clampt(mq[0].t)) void'(mq.pop_front());
  endtask

  task automatic wb_xfer(input logic we, input logic [5:0] adr, input logic [31:0] wd,
                         output logic [31:0] rd, output int lat);
    wb_adr_i = {26'd0, adr};
    wb_dat_i = wd;
    wb_we_i  = we;
    wb_sel_i = 4'hF;
    wb_stb_i = 1'b1;
    wb_cyc_i = 1'b1;
    lat = 0;
    rd  = '0;
    forever begin
      @(posedge clk); #1;
      lat++;
      if (wb_ack_o) break;
      if (lat > 8) begin
        checks++; errors++;
        $error("FAIL wb_ack_timeout observed=no_ack expected=ack adr=0x%0h", adr);
        break;
      end
    end
    rd = wb_dat_o;
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  task automatic wb_write(input logic [5:0] adr, input logic [31:0] d);
    logic [31:0] r;
    int l;
    wb_xfer(1'b1, adr, d, r, l);
  endtask

  task automatic wb_read(input logic [5:0] adr, output logic [31:0] d);
    int l;
    wb_xfer(1'b0, adr, 32'd0, d, l);
  endtask

  task automatic set_rate(input int r);
    wb_write(6'h0C, 32'(r));
    mrate = r;
  endtask

  // Push a command; 'accept' says whether the model expects it queued
  task automatic push_cmd(input int s, input int t, input int h, input bit accept);
    cmd_t c;
    wb_write(6'h00, {3'(s), 13'(h), 16'(t)});
    c.s = s; c.t = t; c.h = h;
    if (accept) mq.push_back(c);
  endtask

  // Follow pw_o cycle by cycle; stop after stop_chg changes, or when idle if 0
  task automatic monitor(input string tag, input int max_cyc, input int stop_chg);
    int n;
    int cyc;
    bit fin;
    n = 0; cyc = 0; fin = 1'b0;
    chg_cyc.delete();
    while (!fin) begin
      @(posedge clk); #1;
      cyc++;
      for (int c = 0; c < 8; c++) begin
        int v;
        v = int'(pw_o[16*c +: 16]);
        if (v != mpw[c]) begin
          int exp_c;
          int exp_v;
          retire();
          if (mq.size() > 0) begin
            exp_c = mq[0].s;
            exp_v = step_to(mpw[c], clampt(mq[0].t), mrate);
          end else begin
            exp_c = 8;
            exp_v = mpw[c];
          end
          chk({tag, "_move_channel"}, 128'(c), 128'(exp_c));
          chk({tag, "_move_value"}, 128'(v), 128'(exp_v));
          mpw[c] = v;
          n++;
          chg_cyc.push_back(cyc_cnt);
        end
      end
      if (stop_chg > 0 && n >= stop_chg) fin = 1'b1;
      else if (stop_chg == 0 && !busy_o) fin = 1'b1;
      else if (cyc >= max_cyc) begin
        checks++; errors++;
        $error("FAIL %s_timeout observed=%0d_cycles expected=completion", tag, cyc);
        fin = 1'b1;
      end
    end
    idle_cyc = cyc_cnt;
  endtask

  task automatic final_check(input string tag);
    logic [31:0] r;
    retire();
    chk({tag, "_queue_drained"}, 128'(mq.size()), 128'(0));
    for (int c = 0; c < 8; c++) begin
      wb_read(6'(32 + 4*c), r);
      chk($sformatf("%s_pw%0d", tag, c), 128'(r), 128'(mpw[c]));
    end
    chk({tag, "_pw_o"}, pw_o, model_vec());
    chk({tag, "_busy_o"}, 128'(busy_o), 128'(0));
  endtask

  initial begin
    logic [31:0] r;
    int lat;
    int d;
    int n;
    int tgt;
    logic [127:0] snap;

    rst = 1'b0;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    wb_we_i = 1'b0; wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    for (int c = 0; c < 8; c++) mpw[c] = 1500;
    mrate = 0;

    // 1. Reset state and bus latency
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pw_o", pw_o, model_vec());
    chk("rst_ack", 128'(wb_ack_o), 128'(0));
    chk("rst_busy", 128'(busy_o), 128'(0));
    chk("rst_irq", 128'(irq_o), 128'(0));
    chk("rst_dat", 128'(wb_dat_o), 128'(0));
    rst = 1'b1;
    @(posedge clk); #1;
    wb_xfer(1'b0, 6'h04, 32'd0, r, lat);
    chk("ack_latency", 128'(lat), 128'(1));
    chk("rst_status", 128'(r), 128'h004);
    @(posedge clk); #1;
    chk("ack_single_cycle", 128'(wb_ack_o), 128'(0));
    wb_read(6'h08, r);  chk("rst_ctrl", 128'(r), 128'(0));
    wb_read(6'h0C, r);  chk("rst_rate", 128'(r), 128'(0));
    wb_read(6'h10, r);  chk("unmapped_read", 128'(r), 128'(0));
    final_check("rst");

    // 2. Ramp servo 2 to 1800 at 100 us/tick, hold 3 ticks
    set_rate(100);
    wb_write(6'h08, 32'h1);
    push_cmd(2, 1800, 3, 1'b1);
    monitor("ramp", 400, 0);
    chk("ramp_steps", 128'(chg_cyc.size()), 128'(3));
    if (chg_cyc.size() == 3) begin
      chk("ramp_tick_gap1", 128'(chg_cyc[1] - chg_cyc[0]), 128'(STEP_DIV));
      chk("ramp_tick_gap2", 128'(chg_cyc[2] - chg_cyc[1]), 128'(STEP_DIV));
      d = idle_cyc - chg_cyc[2];
      chk("hold_3_ticks", 128'(d >= 3*STEP_DIV && d <= 3*STEP_DIV + 2), 128'(1));
    end
    wb_read(6'h04, r);
    chk("ramp_status_done", 128'(r), 128'h014);
    final_check("ramp");

    // 3. RATE=0 jump on servo 7
    wb_write(6'h04, 32'h10);
    set_rate(0);
    push_cmd(7, 900, 0, 1'b1);
    monitor("jump", 200, 0);
    chk("jump_single_step", 128'(chg_cyc.size()), 128'(1));
    final_check("jump");

    // 4. Overflow while disabled, then simultaneous push/pop while full
    wb_write(6'h04, 32'h18);
    wb_write(6'h08, 32'h0);
    set_rate(200);
    for (int i = 0; i < 9; i++)
      push_cmd($urandom_range(0, 7), $urandom_range(600, 2400), $urandom_range(0, 1), i < 8);
    wb_read(6'h04, r);
    chk("full_status", 128'(r), 128'h80B);
    wb_write(6'h04, 32'h08);
    wb_read(6'h04, r);
    chk("ovf_cleared", 128'(r), 128'h803);
    wb_write(6'h08, 32'h1);
    push_cmd($urandom_range(0, 7), $urandom_range(600, 2400), 1, 1'b1);
    wb_read(6'h04, r);
    chk("push_pop_full_level", 128'(r[11:8]), 128'(8));
    chk("push_pop_full_no_ovf", 128'(r[3]), 128'(0));
    monitor("fifo", 6000, 0);
    final_check("fifo");

    // 5. Freeze with enable=0, resume, then flush mid-ramp
    wb_write(6'h04, 32'h18);
    set_rate(10);
    wb_write(6'h08, 32'h1);
    tgt = (mpw[0] >= 1500) ? 500 : 2500;
    push_cmd(0, tgt, 2, 1'b1);
    push_cmd(1, 2000, 0, 1'b1);
    monitor("pre_freeze", 400, 2);
    wb_write(6'h08, 32'h0);
    repeat (3*STEP_DIV) @(posedge clk);
    #1;
    chk("frozen_pw", pw_o, model_vec());
    wb_write(6'h08, 32'h1);
    monitor("resume", 200, 1);
    wb_write(6'h08, 32'h3);
    wb_read(6'h04, r);
    chk("flush_status", 128'(r), 128'h004);
    mq.delete();
    snap = model_vec();
    repeat (3*STEP_DIV) @(posedge clk);
    #1;
    chk("flush_pw_kept", pw_o, snap);
    wb_read(6'h08, r);
    chk("flush_self_clear", 128'(r), 128'h1);
    final_check("flush");

    // 6. Interrupt on completion; clamp when limits are built in
    wb_write(6'h08, 32'h5);
    set_rate(500);
`ifdef SERVO_LIMIT_EN
    push_cmd(3, 3000, 1, 1'b1);
`else
    push_cmd(3, 2000, 1, 1'b1);
`endif
    monitor("irq", 400, 0);
    chk("irq_set", 128'(irq_o), 128'(1));
    wb_read(6'h04, r);
`ifdef SERVO_LIMIT_EN
    chk("irq_status", 128'(r), 128'h034);
    chk("clamped_pw3", 128'(mpw[3]), 128'(2500));
`else
    chk("irq_status", 128'(r), 128'h014);
`endif
    wb_write(6'h04, 32'h10);
    chk("irq_cleared", 128'(irq_o), 128'(0));
`ifdef SERVO_LIMIT_EN
    wb_write(6'h04, 32'h20);
    wb_read(6'h04, r);
    chk("clamp_cleared", 128'(r), 128'h004);
`endif
    final_check("irq");
    wb_write(6'h08, 32'h1);

    // Randomized batches
    for (int b = 0; b < 3; b++) begin
      wb_write(6'h04, 32'h38);
      wb_write(6'h08, 32'h0);
      set_rate(($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(50, 700)));
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++)
        push_cmd($urandom_range(0, 7), $urandom_range(300, 2700), $urandom_range(0, 2), 1'b1);
      wb_write(6'h08, 32'h1);
      monitor($sformatf("rand%0d", b), 6000, 0);
      final_check($sformatf("rand%0d", b));
    end

    // Reset in the middle of a move
    set_rate(50);
    push_cmd(5, (mpw[5] > 1500) ? 600 : 2400, 0, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    for (int c = 0; c < 8; c++) mpw[c] = 1500;
    mq.delete();
    chk("midmove_rst_pw", pw_o, model_vec());
    chk("midmove_rst_busy", 128'(busy_o), 128'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    wb_read(6'h04, r);
    chk("midmove_rst_status", 128'(r), 128'h004);
    wb_read(6'h08, r);
    chk("midmove_rst_ctrl", 128'(r), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
